// File: rtl/tx_pkt_sched.sv
// Packet scheduler for the USB tx buffer: arbitrates command responses and ad-cache
// bursts into 8 packet banks, queues completed banks and tracks the USB read side.
module tx_pkt_sched #(
  parameter int DATA_NBIT = 16,
  parameter int WORD_NBIT = 8,
  parameter int BANK_NBIT = 3
) (
  input  logic                           mclk,
  input  logic                           rst,
  input  logic                           cmd_req,
  input  logic                           cmd_vd,
  input  logic [DATA_NBIT-1:0]           cmd_data,
  input  logic                           cmd_last,
  output logic                           cmd_gnt,
  input  logic                           ad_ready,
  output logic                           ad_rd,
  input  logic [DATA_NBIT-1:0]           ad_data,
  output logic                           tx_vd,
  output logic [WORD_NBIT+BANK_NBIT-1:0] tx_addr,
  output logic [DATA_NBIT-1:0]           tx_data,
  output logic                           tx_eop,
  output logic [BANK_NBIT-1:0]           tx_baddr,
  output logic [WORD_NBIT:0]             tx_len,
  input  logic                           usb_done,
  output logic                           pend,
  output logic                           cmd_ovf
);

  localparam int NBANK = 1 << BANK_NBIT;
  localparam int WORDS = 1 << WORD_NBIT;
  localparam int ANBIT = WORD_NBIT + BANK_NBIT;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_AD, S_CLOSE} state_e;

  state_e                 state_q, state_d;
  logic [BANK_NBIT-1:0]   wbank_q, wbank_d, rbank_q, rbank_d;
  logic [WORD_NBIT:0]     wptr_q, wptr_d;
  logic [BANK_NBIT:0]     count_q, count_d;
  logic [WORD_NBIT-1:0]   rd_cnt_q, rd_cnt_d;
  logic                   last_cmd_q, last_cmd_d;
  logic                   cmd_gnt_q, cmd_gnt_d, ad_rd_q, ad_rd_d;
  logic                   tx_vd_q, tx_vd_d, ad_src_q, ad_src_d;
  logic                   tx_eop_q, tx_eop_d, cmd_ovf_q, cmd_ovf_d;
  logic [ANBIT-1:0]       tx_addr_q, tx_addr_d;
  logic [DATA_NBIT-1:0]   tx_data_q, tx_data_d;
  logic [WORD_NBIT:0]     len_q [NBANK];
  logic                   bank_in, bank_out;

  assign bank_in  = (state_q == S_CLOSE);
  assign bank_out = usb_done && (count_q != '0);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    rd_cnt_d   = rd_cnt_q;
    last_cmd_d = last_cmd_q;
    cmd_gnt_d  = cmd_gnt_q;
    ad_rd_d    = 1'b0;
    tx_vd_d    = 1'b0;
    ad_src_d   = 1'b0;
    tx_eop_d   = 1'b0;
    cmd_ovf_d  = 1'b0;
    tx_addr_d  = tx_addr_q;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != (BANK_NBIT+1)'(NBANK)) begin
          if (cmd_req && (!ad_ready || !last_cmd_q)) begin
            state_d    = S_CMD;
            cmd_gnt_d  = 1'b1;
            last_cmd_d = 1'b1;
          end else if (ad_ready) begin
            state_d    = S_AD;
            ad_rd_d    = 1'b1;
            rd_cnt_d   = '0;
            last_cmd_d = 1'b0;
          end
        end
      end
      S_CMD: begin
        if (cmd_vd) begin
          tx_vd_d   = 1'b1;
          tx_addr_d = {wbank_q, wptr_q[WORD_NBIT-1:0]};
          tx_data_d = cmd_data;
          wptr_d    = wptr_q + 1'b1;
          if (cmd_last || (&wptr_q[WORD_NBIT-1:0])) begin
            state_d   = S_CLOSE;
            cmd_gnt_d = 1'b0;
            tx_eop_d  = 1'b1;
            cmd_ovf_d = !cmd_last;
          end
        end
      end
      S_AD: begin
        // Each read issued now lands as a write next cycle, when ad_data is valid.
        if (ad_rd_q) begin
          rd_cnt_d  = rd_cnt_q + 1'b1;
          ad_rd_d   = (rd_cnt_q != '1);
          tx_vd_d   = 1'b1;
          ad_src_d  = 1'b1;
          tx_addr_d = {wbank_q, wptr_q[WORD_NBIT-1:0]};
          wptr_d    = wptr_q + 1'b1;
        end else if (wptr_q == (WORD_NBIT+1)'(WORDS)) begin
          state_d  = S_CLOSE;
          tx_eop_d = 1'b1;
        end
      end
      S_CLOSE: begin
        wbank_d = wbank_q + 1'b1;
        wptr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bank_out) rbank_d = rbank_q + 1'b1;
    if (bank_in && !bank_out)      count_d = count_q + 1'b1;
    else if (!bank_in && bank_out) count_d = count_q - 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wbank_q    <= '0;
      rbank_q    <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      last_cmd_q <= 1'b0;
      cmd_gnt_q  <= 1'b0;
      ad_rd_q    <= 1'b0;
      tx_vd_q    <= 1'b0;
      ad_src_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      cmd_ovf_q  <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      rd_cnt_q   <= rd_cnt_d;
      last_cmd_q <= last_cmd_d;
      cmd_gnt_q  <= cmd_gnt_d;
      ad_rd_q    <= ad_rd_d;
      tx_vd_q    <= tx_vd_d;
      ad_src_q   <= ad_src_d;
      tx_eop_q   <= tx_eop_d;
      cmd_ovf_q  <= cmd_ovf_d;
      tx_addr_q  <= tx_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // NOTE: the length table is reset because tx_len reads it straight out right after reset.
  always_ff @(posedge mclk) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++) len_q[i] <= '0;
    end else if (bank_in) begin
      len_q[wbank_q] <= wptr_q;
    end
  end

  assign cmd_gnt  = cmd_gnt_q;
  assign ad_rd    = ad_rd_q;
  assign tx_vd    = tx_vd_q;
  assign tx_addr  = tx_addr_q;
  // Ad words are forwarded in the cycle the cache presents them.
  assign tx_data  = ad_src_q ? ad_data : tx_data_q;
  assign tx_eop   = tx_eop_q;
  assign cmd_ovf  = cmd_ovf_q;
  assign tx_baddr = rbank_q;
  assign tx_len   = len_q[rbank_q];
  assign pend     = (count_q != '0);

endmodule
